// File: rtl/key_operand_loader_pkg.sv
// Shared encodings for the operand-entry front end: FSM states and the
// switch / pushbutton field positions on the board.
package key_operand_loader_pkg;

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    ISSUE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int SW_W       = 18;
  localparam int KEY_W      = 4;

  localparam int SW_OPR_LSB = 0;
  localparam int SW_CIN     = 8;
  localparam int SW_OP_LSB  = 16;
  localparam int SW_OP_MSB  = 17;

  localparam int KEY_ENTER  = 1;
  localparam int KEY_CANCEL = 2;

  // Operand field MSB depends on the operand width chosen by the top.
  function automatic int sw_opr_msb(input int width);
    return SW_OPR_LSB + width - 1;
  endfunction

endpackage

// File: rtl/key_operand_loader_if.sv
// Operand-set bus between the loader (master) and the arithmetic datapath (slave).
// Handshake: OPS_VALID rises with a complete set, holds A/B/CIN/OP stable and
// never drops until a clock edge sees OPS_VALID & OPS_READY; that edge is the transfer.
interface key_operand_loader_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic [1:0]       OP;
  logic             OPS_VALID;
  logic             OPS_READY;

  modport master (
    output A, B, CIN, OP, OPS_VALID,
    input  OPS_READY
  );

  modport slave (
    input  A, B, CIN, OP, OPS_VALID,
    output OPS_READY
  );

endinterface

// File: rtl/key_operand_loader_debounce.sv
// One pushbutton: two-flop synchroniser, stability counter and a one-cycle
// press pulse on the debounced 1->0 transition (release is silent).
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic press_o
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any bounce back restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_raw_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= s2_q;
        cnt_q   <= '0;
        press_q <= level_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_operand_loader.sv
// Operand-entry front end: captures A, then B/CIN/OP from the switches on
// debounced enter presses and offers the set to the datapath.
module key_operand_loader
  import key_operand_loader_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int WIDTH      = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [SW_W-1:0]      SW,
  input  logic [KEY_W-1:0]     KEY,
  output logic [1:0]           STATE,
  key_operand_loader_if.master ops
);

  localparam int OPR_MSB = sw_opr_msb(WIDTH);

  logic [SW_W-1:0]  sw_s1_q;
  logic [SW_W-1:0]  sw_s2_q;
  logic             enter_pulse;
  logic             cancel_pulse;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [1:0]       op_q;
  logic             valid_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
    end
  end

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_enter_deb (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .key_raw_i (KEY[KEY_ENTER]),
    .press_o   (enter_pulse)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cancel_deb (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .key_raw_i (KEY[KEY_CANCEL]),
    .press_o   (cancel_pulse)
  );

  // Cancel is tested first in every state that honours it, so it beats a
  // coincident enter; ISSUE looks only at the handshake.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      op_q    <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (cancel_pulse) begin
            state_q <= GET_A;
          end else if (enter_pulse) begin
            a_q     <= sw_s2_q[OPR_MSB:SW_OPR_LSB];
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (cancel_pulse) begin
            state_q <= GET_A;
          end else if (enter_pulse) begin
            b_q     <= sw_s2_q[OPR_MSB:SW_OPR_LSB];
            cin_q   <= sw_s2_q[SW_CIN];
            op_q    <= sw_s2_q[SW_OP_MSB:SW_OP_LSB];
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (ops.OPS_READY) begin
            valid_q <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (cancel_pulse || enter_pulse) begin
            state_q <= GET_A;
          end
        end
        default: begin
          state_q <= GET_A;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign STATE         = state_q;
  assign ops.A         = a_q;
  assign ops.B         = b_q;
  assign ops.CIN       = cin_q;
  assign ops.OP        = op_q;
  assign ops.OPS_VALID = valid_q;

  // Switches and keys that carry no function on this board.
  logic unused_inputs;
  assign unused_inputs = ^{KEY[0], KEY[3], sw_s2_q[SW_OP_LSB-1:SW_CIN+1],
                           sw_s2_q[SW_CIN-1:OPR_MSB+1]};

endmodule

// File: tb/tb_key_operand_loader.sv
// Directed bench for the operand loader: reset, entry, debounce timing,
// handshake stall, cancel priority and asynchronous reset in ISSUE.
module tb_key_operand_loader;

  logic        clk;
  logic        rst_n;
  logic [17:0] sw;
  logic [3:0]  key;
  logic [1:0]  state;

  int n_checks;
  int n_fail;
  int pulse_cnt;
  int first_pulse;

  key_operand_loader_if #(.WIDTH(4)) ops ();

  key_operand_loader #(.DEB_CYCLES(4), .WIDTH(4)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .SW       (sw),
    .KEY      (key),
    .STATE    (state),
    .ops      (ops.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input int idx, input int hold);
    key[idx] = 1'b0;
    repeat (hold) @(negedge clk);
    key[idx] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_both(input int hold);
    key[1] = 1'b0;
    key[2] = 1'b0;
    repeat (hold) @(negedge clk);
    key[1] = 1'b1;
    key[2] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    sw           = '0;
    key          = 4'hF;
    ops.OPS_READY = 1'b0;

    // 1. reset
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'h0);
    check("rst_a", 32'(ops.A), 32'h0);
    check("rst_b", 32'(ops.B), 32'h0);
    check("rst_cin", 32'(ops.CIN), 32'h0);
    check("rst_op", 32'(ops.OP), 32'h0);
    check("rst_valid", 32'(ops.OPS_VALID), 32'h0);
    rst_n = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dut.u_enter_deb.press_o || dut.u_cancel_deb.press_o) pulse_cnt++;
    end
    check("rst_no_pulse", 32'(pulse_cnt), 32'h0);
    check("rst_state_after", 32'(state), 32'h0);

    // 2. full entry sequence
    sw = 18'h00005;
    press_key(1, 10);
    check("entry_a", 32'(ops.A), 32'h5);
    check("entry_state_b", 32'(state), 32'h1);
    sw = 18'h20109;
    press_key(1, 10);
    check("entry_b", 32'(ops.B), 32'h9);
    check("entry_cin", 32'(ops.CIN), 32'h1);
    check("entry_op", 32'(ops.OP), 32'h2);
    check("entry_valid", 32'(ops.OPS_VALID), 32'h1);
    check("entry_state_issue", 32'(state), 32'h2);
    ops.OPS_READY = 1'b1;
    @(negedge clk);
    ops.OPS_READY = 1'b0;
    check("xfer_state_done", 32'(state), 32'h3);
    check("xfer_valid_low", 32'(ops.OPS_VALID), 32'h0);
    check("xfer_a_held", 32'(ops.A), 32'h5);

    // 3. debounce: short glitches ignored, held press yields one timed event
    for (int g = 0; g < 2; g++) begin
      key[1] = 1'b0;
      repeat (3) @(negedge clk);
      key[1] = 1'b1;
      repeat (10) @(negedge clk);
    end
    check("glitch_state", 32'(state), 32'h3);
    pulse_cnt   = 0;
    first_pulse = -1;
    key[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dut.u_enter_deb.press_o) begin
        pulse_cnt++;
        if (first_pulse < 0) first_pulse = k;
      end
      if (k == 10) key[1] = 1'b1;
    end
    check("hold_one_event", 32'(pulse_cnt), 32'h1);
    check("hold_latency", 32'(first_pulse), 32'h6);
    check("hold_state_a", 32'(state), 32'h0);

    // 4. handshake stall with cancel, enter and switch activity
    sw = 18'h00003;
    press_key(1, 10);
    sw = 18'h1000C;
    press_key(1, 10);
    check("stall_pre_state", 32'(state), 32'h2);
    for (int i = 0; i < 30; i++) begin
      if (i == 0)  begin key[2] = 1'b0; sw = 18'h301FF; end
      if (i == 10) key[2] = 1'b1;
      if (i == 12) key[1] = 1'b0;
      if (i == 22) key[1] = 1'b1;
      @(negedge clk);
      check("stall_valid", 32'(ops.OPS_VALID), 32'h1);
    end
    repeat (4) @(negedge clk);
    check("stall_a", 32'(ops.A), 32'h3);
    check("stall_b", 32'(ops.B), 32'hC);
    check("stall_cin", 32'(ops.CIN), 32'h0);
    check("stall_op", 32'(ops.OP), 32'h1);
    check("stall_state", 32'(state), 32'h2);
    ops.OPS_READY = 1'b1;
    @(negedge clk);
    ops.OPS_READY = 1'b0;
    check("stall_xfer_state", 32'(state), 32'h3);
    check("stall_xfer_valid", 32'(ops.OPS_VALID), 32'h0);

    // 5. cancel
    sw = 18'h0;
    press_key(2, 10);
    check("cancel_done", 32'(state), 32'h0);
    sw = 18'h00007;
    press_key(1, 10);
    check("cancel_pre_a", 32'(ops.A), 32'h7);
    check("cancel_pre_state", 32'(state), 32'h1);
    press_key(2, 10);
    check("cancel_getb_state", 32'(state), 32'h0);
    check("cancel_a_kept", 32'(ops.A), 32'h7);
    sw = 18'h00006;
    press_key(1, 10);
    check("both_pre_state", 32'(state), 32'h1);
    sw = 18'h00001;
    press_both(10);
    check("both_cancel_wins", 32'(state), 32'h0);
    check("both_b_kept", 32'(ops.B), 32'hC);
    check("both_a_kept", 32'(ops.A), 32'h6);

    // 6. asynchronous reset while offering a set
    sw = 18'h0000A;
    press_key(1, 10);
    sw = 18'h30105;
    press_key(1, 10);
    check("arst_pre_valid", 32'(ops.OPS_VALID), 32'h1);
    check("arst_pre_b", 32'(ops.B), 32'h5);
    check("arst_pre_op", 32'(ops.OP), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ops.OPS_VALID), 32'h0);
    check("arst_state", 32'(state), 32'h0);
    check("arst_a", 32'(ops.A), 32'h0);
    check("arst_b", 32'(ops.B), 32'h0);
    check("arst_cin", 32'(ops.CIN), 32'h0);
    check("arst_op", 32'(ops.OP), 32'h0);
    check("arst_level", 32'(dut.u_enter_deb.level_q), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_release_state", 32'(state), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
